// File: rtl/mips32_boot_loader.sv
// Streams a program into instruction memory from START_ADDR, then releases the core from reset.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing 32-bit checksum beat.
module mips32_boot_loader #(
   parameter int unsigned ADDR_W      = 10,
   parameter int unsigned START_ADDR  = 1,
   parameter int unsigned RELEASE_DLY = 4,
   parameter logic [31:0] HLT_WORD    = 32'hffff_0000
) (
   input  logic              clk_x,
   input  logic              rst,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   input  logic              s_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_rst_n,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   word_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_APPEND,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] WPTR_START = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] WPTR_MAX   = '1;
   localparam logic [5:0]        HLT_OP     = 6'h3f;
   localparam logic [15:0]       DLY_LAST   = 16'(RELEASE_DLY - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wptr_q, wptr_d;
   logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
   logic                imem_we_q, imem_we_d;
   logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
   logic [31:0]         imem_wdata_q, imem_wdata_d;
   logic                core_rst_n_q, core_rst_n_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [15:0]         since_we_q, since_we_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]         sum_q, sum_d;
   logic                cks_q, cks_d;
   logic                last_hlt_q, last_hlt_d;
   logic                last_max_q, last_max_d;
`endif

   logic accept;
   logic at_max;
   logic is_hlt;

   assign s_ready    = (state_q == S_LOAD);
   assign accept     = s_valid && s_ready;
   assign at_max     = (wptr_q == WPTR_MAX);
   assign is_hlt     = (s_data[31:26] == HLT_OP);

   assign imem_we    = imem_we_q;
   assign imem_addr  = imem_addr_q;
   assign imem_wdata = imem_wdata_q;
   assign core_rst_n = core_rst_n_q;
   assign done       = done_q;
   assign err        = err_q;
   assign word_cnt   = word_cnt_q;

   always_comb begin
      state_d      = state_q;
      wptr_d       = wptr_q;
      word_cnt_d   = word_cnt_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      core_rst_n_d = core_rst_n_q;
      done_d       = done_q;
      err_d        = err_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d        = sum_q;
      cks_d        = cks_q;
      last_hlt_d   = last_hlt_q;
      last_max_d   = last_max_q;
`endif

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d      = S_LOAD;
               wptr_d       = WPTR_START;
               word_cnt_d   = '0;
               err_d        = 1'b0;
               core_rst_n_d = 1'b0;
               done_d       = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               sum_d        = '0;
               cks_d        = 1'b0;
`endif
            end
         end

         S_LOAD: begin
            if (accept) begin
`ifdef LOADER_CHECKSUM_EN
               if (cks_q) begin
                  // Checksum beat: never written, s_last is irrelevant here.
                  if (s_data != sum_q || (!last_hlt_q && last_max_q)) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end else if (last_hlt_q) begin
                     state_d = S_WAIT;
                  end else begin
                     state_d = S_APPEND;
                  end
               end else begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = wptr_q;
                  imem_wdata_d = s_data;
                  word_cnt_d   = word_cnt_q + 1'b1;
                  sum_d        = sum_q + s_data;
                  if (!at_max) wptr_d = wptr_q + 1'b1;
                  if (s_last) begin
                     cks_d      = 1'b1;
                     last_hlt_d = is_hlt;
                     last_max_d = at_max;
                  end else if (at_max) begin
                     state_d = S_ERR;
                     err_d   = 1'b1;
                  end
               end
`else
               imem_we_d    = 1'b1;
               imem_addr_d  = wptr_q;
               imem_wdata_d = s_data;
               word_cnt_d   = word_cnt_q + 1'b1;
               // The pointer saturates so an overflowing stream can never wrap onto address 0.
               if (!at_max) wptr_d = wptr_q + 1'b1;
               if (s_last && is_hlt) begin
                  state_d = S_WAIT;
               end else if (at_max) begin
                  state_d = S_ERR;
                  err_d   = 1'b1;
               end else if (s_last) begin
                  state_d = S_APPEND;
               end
`endif
            end
         end

         S_APPEND: begin
            imem_we_d    = 1'b1;
            imem_addr_d  = wptr_q;
            imem_wdata_d = HLT_WORD;
            word_cnt_d   = word_cnt_q + 1'b1;
            state_d      = S_WAIT;
         end

         S_WAIT: begin
            if (since_we_q >= DLY_LAST) begin
               core_rst_n_d = 1'b1;
               done_d       = 1'b1;
               state_d      = S_DONE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      // Release timing is measured from the most recent write, whatever state issued it.
      if (imem_we_d)               since_we_d = '0;
      else if (since_we_q != '1)   since_we_d = since_we_q + 1'b1;
      else                         since_we_d = since_we_q;
   end

   always_ff @(posedge clk_x) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         wptr_q       <= '0;
         word_cnt_q   <= '0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= '0;
         imem_wdata_q <= '0;
         core_rst_n_q <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         since_we_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= '0;
         cks_q        <= 1'b0;
         last_hlt_q   <= 1'b0;
         last_max_q   <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         wptr_q       <= wptr_d;
         word_cnt_q   <= word_cnt_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         core_rst_n_q <= core_rst_n_d;
         done_q       <= done_d;
         err_q        <= err_d;
         since_we_q   <= since_we_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q        <= sum_d;
         cks_q        <= cks_d;
         last_hlt_q   <= last_hlt_d;
         last_max_q   <= last_max_d;
`endif
      end
   end

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Self-checking bench for mips32_boot_loader: directed and randomized loads against a write-list model.
// Covers the LOADER_CHECKSUM_EN build when that macro is defined.
module tb_mips32_boot_loader;

   localparam int unsigned ADDR_W      = 10;
   localparam int unsigned START_ADDR  = 1;
   localparam int unsigned RELEASE_DLY = 4;
   localparam logic [31:0] HLT_WORD    = 32'hffff_0000;
   localparam int          MAX_WORDS   = (1 << ADDR_W) - START_ADDR;

   logic              clk_x = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [31:0]       s_data = '0;
   logic              s_last = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              core_rst_n;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   word_cnt;

   mips32_boot_loader #(
      .ADDR_W(ADDR_W), .START_ADDR(START_ADDR), .RELEASE_DLY(RELEASE_DLY), .HLT_WORD(HLT_WORD)
   ) dut (
      .clk_x(clk_x), .rst(rst), .start(start), .s_valid(s_valid), .s_ready(s_ready),
      .s_data(s_data), .s_last(s_last), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .core_rst_n(core_rst_n), .done(done), .err(err),
      .word_cnt(word_cnt)
   );

   always #5 clk_x = ~clk_x;

   int testCount = 0;
   int failCount = 0;
   int cycle = 0;
   int lastWeCycle = -1;
   int riseCycle = -1;
   logic doneAtRise = 1'b0;
   logic prevCore = 1'b0;
   logic [ADDR_W-1:0] logAddr[$];
   logic [31:0]       logData[$];
   logic [ADDR_W-1:0] expAddr[$];
   logic [31:0]       expData[$];
   logic [31:0]       prog[$];
`ifdef LOADER_CHECKSUM_EN
   logic [31:0] cksValue = '0;
   bit          useCksValue = 1'b0;
`endif

   // Observe the imem write port and core release one time unit after each rising edge.
   always @(posedge clk_x) begin
      #1;
      cycle++;
      if (imem_we === 1'b1) begin
         logAddr.push_back(imem_addr);
         logData.push_back(imem_wdata);
         lastWeCycle = cycle;
      end
      if (core_rst_n === 1'b1 && prevCore !== 1'b1) begin
         riseCycle  = cycle;
         doneAtRise = done;
      end
      prevCore = core_rst_n;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      testCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulseStart();
      @(negedge clk_x);
      logAddr.delete();
      logData.delete();
      lastWeCycle = -1;
      riseCycle   = -1;
      start = 1'b1;
      @(negedge clk_x);
      start = 1'b0;
      checkOutput("start_s_ready", 64'(s_ready), 64'd1);
      checkOutput("start_core_rst_n", 64'(core_rst_n), 64'd0);
      checkOutput("start_done", 64'(done), 64'd0);
      checkOutput("start_err", 64'(err), 64'd0);
      checkOutput("start_word_cnt", 64'(word_cnt), 64'd0);
   endtask

   // Present one beat after 'gap' idle cycles and hold it until accepted (bounded).
   task automatic sendWord(input logic [31:0] d, input logic l, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         s_valid = 1'b0;
         @(negedge clk_x);
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      n = 0;
      while (s_ready !== 1'b1 && n < 20) begin
         @(negedge clk_x);
         n++;
      end
      if (s_ready !== 1'b1) begin
         checkOutput("accept_timeout", 64'(s_ready), 64'd1);
         s_valid = 1'b0;
      end else begin
         @(posedge clk_x);
         @(negedge clk_x);
      end
   endtask

   // Stream the current program; the checksum beat (if enabled) follows back to back.
   task automatic applyStimulus(input int maxGap);
`ifdef LOADER_CHECKSUM_EN
      logic [31:0] sum;
      sum = '0;
`endif
      for (int i = 0; i < prog.size(); i++) begin
         sendWord(prog[i], i == prog.size() - 1, (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
`ifdef LOADER_CHECKSUM_EN
         sum = sum + prog[i];
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      sendWord(useCksValue ? cksValue : sum, 1'b0, 0);
`endif
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Expected write list: the program at consecutive addresses, plus a halt when it lacks one.
   task automatic buildExpected();
      int n;
      n = prog.size();
      expAddr.delete();
      expData.delete();
      for (int i = 0; i < n; i++) begin
         expAddr.push_back(ADDR_W'(START_ADDR + i));
         expData.push_back(prog[i]);
      end
      if (prog[n-1][31:26] != 6'h3f) begin
         expAddr.push_back(ADDR_W'(START_ADDR + n));
         expData.push_back(HLT_WORD);
      end
   endtask

   task automatic checkLoad(input string tag);
      int n;
      int m;
      buildExpected();
      n = 0;
      while (done !== 1'b1 && n < 400) begin
         @(negedge clk_x);
         n++;
      end
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_core_rst_n"}, 64'(core_rst_n), 64'd1);
      checkOutput({tag, "_err"}, 64'(err), 64'd0);
      checkOutput({tag, "_s_ready"}, 64'(s_ready), 64'd0);
      checkOutput({tag, "_word_cnt"}, 64'(word_cnt), 64'(expAddr.size()));
      checkOutput({tag, "_write_count"}, 64'(logAddr.size()), 64'(expAddr.size()));
      m = (logAddr.size() < expAddr.size()) ? logAddr.size() : expAddr.size();
      for (int i = 0; i < m; i++) begin
         checkOutput({tag, "_addr"}, 64'(logAddr[i]), 64'(expAddr[i]));
         checkOutput({tag, "_data"}, 64'(logData[i]), 64'(expData[i]));
      end
      checkOutput({tag, "_release_delay"}, 64'(riseCycle - lastWeCycle), 64'(RELEASE_DLY));
      checkOutput({tag, "_done_at_release"}, 64'(doneAtRise), 64'd1);
   endtask

   task automatic loadBasic();
      prog = '{32'hc020_0001, 32'hc040_0002, 32'h0000_0000, 32'h0061_1000,
               32'h4883_0002, 32'hc480_0003, 32'hd000_0005, 32'hffff_0005};
   endtask

   initial begin
      logic [31:0] w;
      int len;

      // Reset state
      rst = 1'b0;
      repeat (3) @(negedge clk_x);
      checkOutput("rst_s_ready", 64'(s_ready), 64'd0);
      checkOutput("rst_imem_we", 64'(imem_we), 64'd0);
      checkOutput("rst_imem_addr", 64'(imem_addr), 64'd0);
      checkOutput("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      checkOutput("rst_core_rst_n", 64'(core_rst_n), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_word_cnt", 64'(word_cnt), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk_x);

      // Basic eight-word program ending in a halt
      loadBasic();
      pulseStart();
      applyStimulus(0);
      checkLoad("basic");

      // Program without a halt gets HLT_WORD appended (reload from DONE)
      prog = '{32'h0061_1000};
      pulseStart();
      applyStimulus(0);
      checkLoad("missing_halt");

      // Same basic program with random valid gaps
      loadBasic();
      pulseStart();
      applyStimulus(5);
      checkLoad("gaps");

      // Randomized programs, halt present or not
      for (int t = 0; t < 6; t++) begin
         prog.delete();
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) begin
            w = $urandom;
            prog.push_back(w);
         end
         if ($urandom_range(0, 1) == 1) prog[len-1][31:26] = 6'h3f;
         else if (prog[len-1][31:26] == 6'h3f) prog[len-1][31] = 1'b0;
         pulseStart();
         applyStimulus(3);
         checkLoad("random");
      end

      // Reset after three accepted words
      loadBasic();
      pulseStart();
      for (int i = 0; i < 3; i++) sendWord(prog[i], 1'b0, 0);
      rst = 1'b0;
      s_valid = 1'b0;
      @(negedge clk_x);
      checkOutput("midrst_s_ready", 64'(s_ready), 64'd0);
      checkOutput("midrst_imem_we", 64'(imem_we), 64'd0);
      checkOutput("midrst_imem_addr", 64'(imem_addr), 64'd0);
      checkOutput("midrst_imem_wdata", 64'(imem_wdata), 64'd0);
      checkOutput("midrst_core_rst_n", 64'(core_rst_n), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_err", 64'(err), 64'd0);
      checkOutput("midrst_word_cnt", 64'(word_cnt), 64'd0);
      repeat (3) @(negedge clk_x);
      rst = 1'b1;
      repeat (3) @(negedge clk_x);
      checkOutput("midrst_writes", 64'(logAddr.size()), 64'd3);
      checkOutput("midrst_idle_ready", 64'(s_ready), 64'd0);
      pulseStart();
      applyStimulus(0);
      checkLoad("reload_after_rst");

      // Overflow: a full window of non-halt words and no s_last
      pulseStart();
      for (int i = 0; i < MAX_WORDS; i++) begin
         w = $urandom;
         if (w[31:26] == 6'h3f) w[31] = 1'b0;
         sendWord(w, 1'b0, 0);
      end
      s_valid = 1'b1;
      s_data  = 32'h1234_5678;
      repeat (3) @(negedge clk_x);
      s_valid = 1'b0;
      checkOutput("ovf_err", 64'(err), 64'd1);
      checkOutput("ovf_s_ready", 64'(s_ready), 64'd0);
      checkOutput("ovf_core_rst_n", 64'(core_rst_n), 64'd0);
      checkOutput("ovf_done", 64'(done), 64'd0);
      checkOutput("ovf_word_cnt", 64'(word_cnt), 64'(MAX_WORDS));
      checkOutput("ovf_writes", 64'(logAddr.size()), 64'(MAX_WORDS));
      if (logAddr.size() > 0) begin
         checkOutput("ovf_first_addr", 64'(logAddr[0]), 64'(START_ADDR));
         checkOutput("ovf_last_addr", 64'(logAddr[logAddr.size()-1]), 64'((1 << ADDR_W) - 1));
      end

      // Recovery from ERR through start
      loadBasic();
      pulseStart();
      applyStimulus(0);
      checkLoad("after_err");

`ifdef LOADER_CHECKSUM_EN
      prog = '{32'h0000_0001, 32'hffff_0000};
      useCksValue = 1'b1;
      cksValue = 32'hffff_0001;
      pulseStart();
      applyStimulus(0);
      checkLoad("cks_match");
      cksValue = 32'h0000_0000;
      pulseStart();
      applyStimulus(0);
      repeat (2) @(negedge clk_x);
      checkOutput("cks_bad_err", 64'(err), 64'd1);
      checkOutput("cks_bad_core_rst_n", 64'(core_rst_n), 64'd0);
      checkOutput("cks_bad_done", 64'(done), 64'd0);
      checkOutput("cks_bad_writes", 64'(logAddr.size()), 64'd2);
      useCksValue = 1'b0;
`endif

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
